imm_gen_stage: RTL

//  Parametrised, pipelined successor to the combinational immediate generator. Sits between ID and EX.

---
 rtl/imm_gen_pkg.sv | 21 ++
 rtl/imm_gen_core.sv | 58 +++++
 rtl/imm_gen_stage.sv | 87 ++++++++
 3 files changed

// File: rtl/imm_gen_pkg.sv
// Shared constants for the pipelined immediate generator: format encodings
// and the select bit that chooses zero- versus sign-extension.
package imm_gen_pkg;

    localparam logic [2:0] FMT_U     = 3'b000;
    localparam logic [2:0] FMT_J     = 3'b001;
    localparam logic [2:0] FMT_I     = 3'b010;
    localparam logic [2:0] FMT_B     = 3'b011;
    localparam logic [2:0] FMT_S     = 3'b100;
    localparam logic [2:0] FMT_SHAMT = 3'b101;
    localparam logic [2:0] FMT_ZIMM  = 3'b110;
    localparam logic [2:0] FMT_ILLEG = 3'b111;

    localparam int ZEXT_BIT = 3;

    // Fill bit for the signed formats: the instruction sign unless zero-extension is selected.
    function automatic logic ext_fill(input logic [3:0] sel, input logic sign);
        return sel[ZEXT_BIT] ? 1'b0 : sign;
    endfunction

endpackage

// File: rtl/imm_gen_core.sv
// Combinational immediate decoder: INSTR/SEL to an XLEN-wide immediate plus
// an illegal-format flag.
module imm_gen_core
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [3:0]      sel,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    logic        ext;
    logic        fill;
    logic        shamt_hi;
    logic [31:0] raw;
    logic        unused_opcode;

    assign ext           = ext_fill(sel, instr[31]);
    assign shamt_hi      = (XLEN == 64) ? instr[25] : 1'b0;
    assign unused_opcode = ^instr[6:0];

    always_comb begin
        err  = 1'b0;
        fill = 1'b0;
        raw  = 32'b0;
        case (sel[2:0])
            FMT_U: begin
                // U-type ignores the zero-extend bit; upper bits always follow INSTR[31].
                raw  = {instr[31:12], 12'b0};
                fill = instr[31];
            end
            FMT_J: begin
                raw  = {{11{ext}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                fill = ext;
            end
            FMT_I: begin
                raw  = {{20{ext}}, instr[31:20]};
                fill = ext;
            end
            FMT_B: begin
                raw  = {{19{ext}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                fill = ext;
            end
            FMT_S: begin
                raw  = {{20{ext}}, instr[31:25], instr[11:7]};
                fill = ext;
            end
            FMT_SHAMT: raw = {26'b0, shamt_hi, instr[24:20]};
            FMT_ZIMM:  raw = {27'b0, instr[19:15]};
            default:   err = 1'b1;
        endcase
        imm       = {XLEN{fill}};
        imm[31:0] = raw;
    end

endmodule

// File: rtl/imm_gen_stage.sv
// ID->EX immediate stage: decoded result registered into a two-entry skid
// buffer (entry 0 drives the outputs) with valid/ready handshaking and flush.
module imm_gen_stage
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [3:0]       sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic             err,
    output logic [TAG_W-1:0] out_tag
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic             err;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t          e0;
    entry_t          e1;
    entry_t          in_entry;
    logic            e0_full;
    logic            e1_full;
    logic [XLEN-1:0] dec_imm;
    logic            dec_err;
    logic            accept;
    logic            xfer;

    imm_gen_core #(.XLEN(XLEN)) u_core (
        .instr (instr),
        .sel   (sel),
        .imm   (dec_imm),
        .err   (dec_err)
    );

    assign in_entry = '{imm: dec_imm, err: dec_err, tag: in_tag};
    assign accept   = in_valid & in_ready;
    assign xfer     = e0_full & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0      <= '0;
            e1      <= '0;
            e0_full <= 1'b0;
            e1_full <= 1'b0;
        end else if (flush) begin
            e0_full <= 1'b0;
            e1_full <= 1'b0;
        end else if (xfer) begin
            // in_ready is low whenever entry 1 is full, so accept and refill-from-skid never coincide.
            if (e1_full) begin
                e0      <= e1;
                e1_full <= 1'b0;
            end else if (accept) begin
                e0 <= in_entry;
            end else begin
                e0_full <= 1'b0;
            end
        end else if (accept) begin
            if (!e0_full) begin
                e0      <= in_entry;
                e0_full <= 1'b1;
            end else begin
                e1      <= in_entry;
                e1_full <= 1'b1;
            end
        end
    end

    assign in_ready  = ~e1_full;
    assign out_valid = e0_full;
    assign imm       = e0.imm;
    assign err       = e0.err;
    assign out_tag   = e0.tag;

endmodule
